// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave front end: synchronises the pins, shifts in one
// opcode/A/B frame per chip-select window, hands it off over valid/ready.
module spi_frame_receiver #(
  parameter int OPCODE_WIDTH  = 8,
  parameter int OPERAND_WIDTH = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     spi_sclk,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  output logic                     frm_valid,
  input  logic                     frm_ready,
  output logic [OPCODE_WIDTH-1:0]  frm_opcode,
  output logic [OPERAND_WIDTH-1:0] frm_op_a,
  output logic [OPERAND_WIDTH-1:0] frm_op_b,
  output logic                     busy,
  output logic                     abort_pulse,
  output logic                     overrun
);
  localparam int FRAME_BITS = OPCODE_WIDTH + 2*OPERAND_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [FRAME_BITS-1:0]  shreg;
  logic                   shift_en, frame_cpl, abort_nxt, frame_done;
  logic                   accept;

  // MOSI rides the same synchroniser depth as SCLK so the bit lines up with its edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    frame_cpl = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      IDLE: if (cs_fall) begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_en = 1'b1;
          cnt_nxt  = cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state_nxt = DONE;
            frame_cpl = 1'b1;
          end
        end
        // a final bit landing with CS rising still counts as a complete frame
        if (cs_rise && !frame_cpl) begin
          state_nxt = IDLE;
          abort_nxt = (cnt_nxt != '0);
        end
      end
      DONE: if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      frame_done  <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      frame_done  <= frame_cpl;
      abort_pulse <= abort_nxt;
      if (shift_en) shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
    end
  end

  assign busy   = (state == SHIFT);
  assign accept = frm_valid & frm_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_valid  <= 1'b0;
      frm_opcode <= '0;
      frm_op_a   <= '0;
      frm_op_b   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (frame_done && (!frm_valid || frm_ready)) begin
        frm_valid  <= 1'b1;
        frm_opcode <= shreg[FRAME_BITS-1 -: OPCODE_WIDTH];
        frm_op_a   <= shreg[FRAME_BITS-OPCODE_WIDTH-1 -: OPERAND_WIDTH];
        frm_op_b   <= shreg[OPERAND_WIDTH-1:0];
      end else if (accept) begin
        frm_valid <= 1'b0;
      end
      // set is written last so it wins over a same-cycle clear
      if (accept) overrun <= 1'b0;
      if (frame_done && frm_valid && !frm_ready) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: directed corner cases plus a randomized
// frame stream checked against a queue of expected frames.
module tb_spi_frame_receiver;
  logic        clk = 0, rst_n = 1;
  logic        spi_sclk = 0, spi_cs_n = 1, spi_mosi = 0, frm_ready = 0;
  logic        frm_valid, busy, abort_pulse, overrun;
  logic [7:0]  frm_opcode;
  logic [31:0] frm_op_a, frm_op_b;

  int n_tests = 0, n_fail = 0;
  int valid_cyc = 0, abort_cyc = 0;
  logic [71:0] got_q[$];
  logic [71:0] exp_q[$];
  logic        held = 0;
  logic [71:0] held_f;

  always #5 clk = ~clk;

  spi_frame_receiver dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_opcode(frm_opcode), .frm_op_a(frm_op_a), .frm_op_b(frm_op_b),
    .busy(busy), .abort_pulse(abort_pulse), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] fields();
    return {frm_opcode, frm_op_a, frm_op_b};
  endfunction

  function automatic logic [75:0] all_outs();
    return {frm_valid, busy, abort_pulse, overrun, frm_opcode, frm_op_a, frm_op_b};
  endfunction

  function automatic logic [79:0] rnd80();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[79:0];
  endfunction

  // monitor: sample just after the falling edge, i.e. the values the next rising edge sees
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (frm_valid) valid_cyc++;
      if (abort_pulse) abort_cyc++;
      if (held && frm_valid) chk("stable", 96'(fields()), 96'(held_f));
      if (frm_valid && frm_ready) got_q.push_back(fields());
      held   = frm_valid && !frm_ready;
      held_f = fields();
    end else begin
      held = 0;
    end
  end

  // bits are MSB-aligned: bit 79 goes first
  task automatic spi_send(input logic [79:0] bits, input int n, input bit end_cs);
    @(negedge clk);
    #3;
    spi_cs_n = 0;
    #40;
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[79-i];
      #40 spi_sclk = 1;
      #40 spi_sclk = 0;
    end
    if (end_cs) begin
      #40 spi_cs_n = 1;
      #80;
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input logic [71:0] exp);
    chk({tag, "_cnt"}, 96'(got_q.size()), 96'd1);
    if (got_q.size() > 0) chk(tag, 96'(got_q.pop_front()), 96'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, a0, na, t;
    logic [79:0] bits;
    logic [71:0] x, y, e;
    bit done;

    #2 rst_n = 0;
    #1 chk("rst_outs", 96'(all_outs()), 96'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // basic frame, ready high
    frm_ready = 1; v0 = valid_cyc; a0 = abort_cyc;
    spi_send({8'h01, 32'h3F800000, 32'h40000000, 8'h00}, 72, 1);
    settle();
    expect_frame("t1_frame", {8'h01, 32'h3F800000, 32'h40000000});
    chk("t1_vcyc", 96'(valid_cyc - v0), 96'd1);
    chk("t1_ovr", 96'(overrun), 96'd0);
    chk("t1_abort", 96'(abort_cyc - a0), 96'd0);

    // held frame, second frame overruns
    frm_ready = 0;
    x = {8'h02, 32'h11111111, 32'h22222222};
    spi_send({x, 8'h00}, 72, 1);
    settle();
    chk("t2_valid", 96'(frm_valid), 96'd1);
    chk("t2_fields", 96'(fields()), 96'(x));
    chk("t2_ovr0", 96'(overrun), 96'd0);
    spi_send({8'h03, 32'h33333333, 32'h44444444, 8'h00}, 72, 1);
    settle();
    chk("t2_ovr1", 96'(overrun), 96'd1);
    chk("t2_hold", 96'({frm_valid, fields()}), 96'({1'b1, x}));
    frm_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t2_drop", 96'({frm_valid, overrun}), 96'd0);
    expect_frame("t2_frame", x);

    // abort after 20 bits, then a clean frame
    v0 = valid_cyc; a0 = abort_cyc;
    spi_send(rnd80(), 20, 1);
    settle();
    chk("t3_abort", 96'(abort_cyc - a0), 96'd1);
    chk("t3_busy", 96'(busy), 96'd0);
    chk("t3_novalid", 96'(valid_cyc - v0), 96'd0);
    bits = rnd80();
    spi_send(bits, 72, 1);
    settle();
    expect_frame("t3_frame", bits[79:8]);

    // 80 edges: only the first 72 bits count
    v0 = valid_cyc;
    bits = rnd80();
    spi_send(bits, 80, 1);
    settle();
    expect_frame("t4_frame", bits[79:8]);
    chk("t4_vcyc", 96'(valid_cyc - v0), 96'd1);

    // new frame completes in the same cycle the held one is consumed
    frm_ready = 0;
    bits = rnd80(); x = bits[79:8];
    spi_send(bits, 72, 1);
    settle();
    chk("t5_held", 96'(frm_valid), 96'd1);
    bits = rnd80(); y = bits[79:8];
    fork
      spi_send(bits, 72, 1);
      begin
        t = 0;
        while (!busy && t < 2000) begin @(negedge clk); t++; end
        while (busy && t < 2000) begin @(negedge clk); t++; end
        chk("t5_sync", 96'(t < 2000), 96'd1);
        frm_ready = 1;
        @(negedge clk);
        #2;
        chk("t5_state", 96'({frm_valid, overrun}), 96'b10);
        chk("t5_fields", 96'(fields()), 96'(y));
      end
    join
    settle();
    chk("t5_cnt", 96'(got_q.size()), 96'd2);
    if (got_q.size() > 0) chk("t5_old", 96'(got_q.pop_front()), 96'(x));
    if (got_q.size() > 0) chk("t5_new", 96'(got_q.pop_front()), 96'(y));

    // reset mid-frame
    a0 = abort_cyc;
    spi_send(rnd80(), 40, 0);
    #7 rst_n = 0;
    #1 chk("t6_rst", 96'(all_outs()), 96'd0);
    spi_cs_n = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    bits = rnd80();
    spi_send(bits, 72, 1);
    settle();
    expect_frame("t6_frame", bits[79:8]);
    chk("t6_abort", 96'(abort_cyc - a0), 96'd0);

    // randomized stream: full frames (with spare trailing edges) and aborts
    a0 = abort_cyc; na = 0; done = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          bits = rnd80();
          if ($urandom_range(0, 3) == 0) begin
            na++;
            spi_send(bits, $urandom_range(1, 71), 1);
          end else begin
            exp_q.push_back(bits[79:8]);
            spi_send(bits, 72 + $urandom_range(0, 8), 1);
          end
        end
        settle();
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          frm_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    frm_ready = 1;
    settle();
    chk("rnd_cnt", 96'(got_q.size()), 96'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rnd_frame", 96'(got_q.pop_front()), 96'(e));
    end
    chk("rnd_abort", 96'(abort_cyc - a0), 96'(na));
    chk("rnd_ovr", 96'(overrun), 96'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
